// File: rtl/tdm_demux2_rx.sv
// tdm_demux2_rx: serial two-channel TDM receiver; din/din_valid/fsync in, a_data/a_valid, b_data/b_valid, sync_err, locked out
module tdm_demux2_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  output logic             sync_err,
  output logic             locked
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {HUNT, CH_A, CH_B} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic             frame_start;
  logic             last;
  assign word        = {sr[WIDTH-2:0], din};
  assign frame_start = state == CH_A && cnt == '0;
  assign last        = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      cnt      <= '0;
      sr       <= '0;
      a_data   <= '0;
      b_data   <= '0;
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      sync_err <= 1'b0;
      locked   <= 1'b0;
    end else begin
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      sync_err <= 1'b0;
      if (din_valid) begin
        if (state == HUNT) begin
          if (fsync) begin
            sr     <= {{(WIDTH-1){1'b0}}, din};
            cnt    <= CW'(1);
            state  <= CH_A;
            locked <= 1'b1;
          end
        end else if (frame_start && !fsync) begin
          sync_err <= 1'b1;
          state    <= HUNT;
          locked   <= 1'b0;
        end else if (fsync && !frame_start) begin
          sync_err <= 1'b1;
          sr       <= {{(WIDTH-1){1'b0}}, din};
          cnt      <= CW'(1);
          state    <= CH_A;
        end else if (last) begin
          sr  <= word;
          cnt <= '0;
          if (state == CH_A) begin
            a_data  <= word;
            a_valid <= 1'b1;
            state   <= CH_B;
          end else begin
            b_data  <= word;
            b_valid <= 1'b1;
            state   <= CH_A;
          end
        end else begin
          sr  <= word;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux2_rx.sv
// tb_tdm_demux2_rx: table-driven check of the two-channel TDM receiver
module tb_tdm_demux2_rx;
  typedef struct {
    logic       rst, dv, din, fs;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       err, lk;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst, din, din_valid, fsync;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, sync_err, locked;
  vec_t       vecs[$];
  logic [7:0] ead = '0, ebd = '0;
  logic       elk = 1'b0;
  int         applied = 0, miscompares = 0;
  always #5 clk = ~clk;
  tdm_demux2_rx #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .fsync(fsync),
    .a_data(a_data), .a_valid(a_valid), .b_data(b_data), .b_valid(b_valid),
    .sync_err(sync_err), .locked(locked)
  );
  task automatic push(input logic r, dv, d, fs, av, bv, err);
    vec_t v;
    v.rst = r; v.dv = dv; v.din = d; v.fs = fs;
    v.av = av; v.ad = ead; v.bv = bv; v.bd = ebd; v.err = err; v.lk = elk;
    vecs.push_back(v);
  endtask
  task automatic stall(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 1'b0, 1'(($urandom)), 1'(($urandom)), 1'b0, 1'b0, 1'b0);
  endtask
  task automatic word(input logic [7:0] w, input logic ch, input logic fs0, input logic err0,
                      input int n, input int sp, input int ns);
    for (int i = 0; i < n; i++) begin
      logic done;
      if (i == sp) stall(ns);
      if (i == 0 && fs0) elk = 1'b1;
      done = (i == 7);
      if (done && !ch) ead = w;
      if (done && ch) ebd = w;
      push(1'b0, 1'b1, w[7-i], fs0 && i == 0, done && !ch, done && ch, err0 && i == 0);
    end
  endtask
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input int sp, input int ns);
    word(a, 1'b0, 1'b1, 1'b0, 8, sp, ns);
    word(b, 1'b1, 1'b0, 1'b0, 8, sp, ns);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: vector replay did not finish");
    $finish;
  end
  initial begin
    for (int k = 0; k < 3; k++) push(1'b1, 1'(($urandom)), 1'(($urandom)), 1'(($urandom)), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) push(1'b0, 1'b1, k[0], 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'hA5, 8'h3C, -1, 0);
    frame(8'h12, 8'h34, 3, 3);
    frame(8'hFE, 8'h01, 5, 3);
    elk = 1'b0;
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'h5A, 8'hC3, -1, 0);
    word(8'h11, 1'b0, 1'b1, 1'b0, 8, -1, 0);
    word(8'h22, 1'b1, 1'b0, 1'b0, 4, -1, 0);
    word(8'h9B, 1'b0, 1'b1, 1'b1, 8, -1, 0);
    word(8'h66, 1'b1, 1'b0, 1'b0, 8, -1, 0);
    word(8'h77, 1'b0, 1'b1, 1'b0, 8, -1, 0);
    word(8'hFF, 1'b1, 1'b0, 1'b0, 3, -1, 0);
    ead = '0; ebd = '0; elk = 1'b0;
    push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'h3E, 8'hD4, -1, 0);
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; fsync = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; din_valid = vecs[i].dv; din = vecs[i].din; fsync = vecs[i].fs;
      @(posedge clk);
      #1;
      applied++;
      if (vecs[i].rst && {a_valid, a_data, b_valid, b_data, sync_err, locked} !== '0) begin
        miscompares++;
        $display("FAIL vec%0d reset state not all zero: av=%b ad=%h bv=%b bd=%h err=%b lk=%b",
                 i, a_valid, a_data, b_valid, b_data, sync_err, locked);
      end
      if ({a_valid, a_data, b_valid, b_data, sync_err, locked} !==
          {vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].err, vecs[i].lk}) begin
        miscompares++;
        $display("FAIL vec%0d got av=%b ad=%h bv=%b bd=%h err=%b lk=%b want av=%b ad=%h bv=%b bd=%h err=%b lk=%b",
                 i, a_valid, a_data, b_valid, b_data, sync_err, locked,
                 vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].err, vecs[i].lk);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    if (miscompares != 0 || applied != vecs.size()) $display("FAIL");
    else $display("PASS");
    $finish;
  end
endmodule
